jtdsp16_rom_fetch: RTL

- Responder side of the XAAU program-fetch interface: takes the 16-bit rom_addr the address unit issues and returns rom_dout plus a valid flag, rom_ok.
- Backed by a direct-mapped, one-word-per-line cache in front of a slow external program memory (SDRAM-style cs/ok handshake).
- The clock-enable generator gates ph1 with rom_ok, so a miss stalls the core with no other logic involved.

---
 rtl/jtdsp16_pkg.sv | 16 +
 rtl/jtdsp16_rom_fetch_if.sv | 13 +
 rtl/jtdsp16_rom_cache_mem.sv | 53 +++++
 rtl/jtdsp16_rom_fetch.sv | 129 ++++++++++++
 4 files changed

// File: rtl/jtdsp16_pkg.sv
// Shared definitions for the JTDSP16 program-fetch slice:
// fetch FSM state encodings, ROM address/data widths and the cache tag width.
package jtdsp16_pkg;

  localparam logic ST_CHECK = 1'b0;
  localparam logic ST_FILL  = 1'b1;

  localparam int ROM_AW = 16;
  localparam int ROM_DW = 16;

  // Number of address bits kept as tag for a cache with 2**cache_aw lines
  function automatic int tag_w(input int cache_aw);
    return ROM_AW - cache_aw;
  endfunction

endpackage

// File: rtl/jtdsp16_rom_fetch_if.sv
// Program-fetch bus between the XAAU (master: issues rom_addr) and the
// ROM fetch unit (slave: returns rom_dout qualified by rom_ok).
interface jtdsp16_rom_fetch_if;
  import jtdsp16_pkg::*;

  logic [ROM_AW-1:0] rom_addr;
  logic [ROM_DW-1:0] rom_dout;
  logic              rom_ok;

  modport master (output rom_addr, input rom_dout, input rom_ok);
  modport slave  (input rom_addr, output rom_dout, output rom_ok);

endinterface

// File: rtl/jtdsp16_rom_cache_mem.sv
// Direct-mapped, one-word-per-line cache storage: tag/data/valid arrays
// with a combinational read port, one write port and a flush-all input.
// Only the valid bits are reset; tag and data contents are don't-care
// until their line has been written.
module jtdsp16_rom_cache_mem
  import jtdsp16_pkg::*;
#(
  parameter int CACHE_AW = 6,
  parameter int TW       = tag_w(CACHE_AW)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [CACHE_AW-1:0] rd_idx,
  output logic [TW-1:0]       rd_tag,
  output logic [ROM_DW-1:0]   rd_data,
  output logic                rd_valid,
  input  logic                we,
  input  logic [CACHE_AW-1:0] wr_idx,
  input  logic [TW-1:0]       wr_tag,
  input  logic [ROM_DW-1:0]   wr_data
);

  localparam int LINES = 1 << CACHE_AW;

  logic [TW-1:0]     tag_mem  [LINES];
  logic [ROM_DW-1:0] data_mem [LINES];
  logic [LINES-1:0]  valid;

  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];
  assign rd_valid = valid[rd_idx];

  // Line contents: written only by a completed fill
  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  // Valid bits: flush wins over a same-cycle write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (flush) begin
      valid <= '0;
    end else if (we) begin
      valid[wr_idx] <= 1'b1;
    end
  end

endmodule

// File: rtl/jtdsp16_rom_fetch.sv
// JTDSP16 program-fetch responder: a direct-mapped cache in front of a slow
// external program memory. A miss holds rom_ok low, which gates ph1 and
// stalls the core until the fill returns.
// Optional build macro: JTDSP16_ROMSTATS_EN adds hit_cnt/miss_cnt outputs.
module jtdsp16_rom_fetch
  import jtdsp16_pkg::*;
#(
  parameter int CACHE_AW = 6
) (
  input  logic                 rst,
  input  logic                 clk,
  input  logic                 flush,
  jtdsp16_rom_fetch_if.slave   rom,
  output logic [ROM_AW-1:0]    ext_addr,
  output logic                 ext_cs,
  input  logic [ROM_DW-1:0]    ext_data,
  input  logic                 ext_ok
`ifdef JTDSP16_ROMSTATS_EN
  ,
  output logic [15:0]          hit_cnt,
  output logic [15:0]          miss_cnt
`endif
);

  localparam int TW = tag_w(CACHE_AW);

  logic              state;
  logic [ROM_DW-1:0] dout_r;
  logic              ok_r;
  logic [ROM_AW-1:0] chk_addr;   // address looked up on the previous clk
  logic              flush_pend; // flush seen during the current fill

  logic [TW-1:0]     rd_tag;
  logic [ROM_DW-1:0] rd_data;
  logic              rd_valid;
  logic              hit;
  logic              fill_done;
  logic              we;

  assign hit       = rd_valid && (rd_tag == rom.rom_addr[ROM_AW-1:CACHE_AW]) && !flush;
  assign fill_done = (state == ST_FILL) && ext_cs && ext_ok;
  assign we        = fill_done && !flush_pend && !flush;

  jtdsp16_rom_cache_mem #(.CACHE_AW(CACHE_AW), .TW(TW)) u_mem (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .rd_idx   (rom.rom_addr[CACHE_AW-1:0]),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .we       (we),
    .wr_idx   (ext_addr[CACHE_AW-1:0]),
    .wr_tag   (ext_addr[ROM_AW-1:CACHE_AW]),
    .wr_data  (ext_data)
  );

  // The registered valid flag is only trusted while the core still presents
  // the address it was computed for; a fresh address reads as not-ready
  // until it has been looked up, so the core never advances on stale data.
  assign rom.rom_dout = dout_r;
  assign rom.rom_ok   = ok_r && (rom.rom_addr == chk_addr);

  // Fetch FSM: lookup in CHECK, external request/response in FILL
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_CHECK;
      dout_r     <= 16'h0000;
      ok_r       <= 1'b0;
      chk_addr   <= 16'h0000;
      ext_addr   <= 16'h0000;
      ext_cs     <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      chk_addr <= rom.rom_addr;
      case (state)
        ST_CHECK: begin
          dout_r     <= rd_data;
          ok_r       <= hit;
          flush_pend <= 1'b0;
          if (!hit && !flush) begin
            ext_addr <= rom.rom_addr;
            ext_cs   <= 1'b1;
            state    <= ST_FILL;
          end
        end
        ST_FILL: begin
          ok_r <= 1'b0;
          if (flush) begin
            flush_pend <= 1'b1;
          end
          if (fill_done) begin
            dout_r     <= ext_data;
            ok_r       <= (rom.rom_addr == ext_addr);
            ext_cs     <= 1'b0;
            flush_pend <= 1'b0;
            state      <= ST_CHECK;
          end
        end
        default: begin
          state  <= ST_CHECK;
          ok_r   <= 1'b0;
          ext_cs <= 1'b0;
        end
      endcase
    end
  end

`ifdef JTDSP16_ROMSTATS_EN
  // Saturating hit/miss statistics; flush clears them in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= 16'h0000;
      miss_cnt <= 16'h0000;
    end else if (flush) begin
      hit_cnt  <= 16'h0000;
      miss_cnt <= 16'h0000;
    end else if (state == ST_CHECK) begin
      if (hit && (hit_cnt != 16'hFFFF)) begin
        hit_cnt <= hit_cnt + 16'h0001;
      end
      if (!hit && (miss_cnt != 16'hFFFF)) begin
        miss_cnt <= miss_cnt + 16'h0001;
      end
    end
  end
`endif

endmodule
